digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry.sv | 111 +++++++++++
 tb/tb_digit_entry.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// Four-digit BCD keypad entry FSM with ENTER/CLEAR handling.
// Optional inactivity timeout enabled by DIGIT_ENTRY_TIMEOUT_EN.
module digit_entry #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [15:0] digits_out,
   output logic [2:0]  count,
   output logic        entry_valid,
   output logic        entry_done,
   output logic        err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ENTRY = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0] state;
   logic       is_digit;
   logic       is_clear;
   logic       is_enter;
   logic       is_rsvd;
   logic       timeout_hit;

   assign is_digit = key_code <= 4'h9;
   assign is_clear = key_code == 4'hA;
   assign is_enter = key_code == 4'hB;
   assign is_rsvd  = key_code >= 4'hC;

`ifdef DIGIT_ENTRY_TIMEOUT_EN
   logic [23:0] tmr;
   logic        tmr_run;

   assign tmr_run     = (state == ENTRY) || (state == FULL);
   assign timeout_hit = tmr_run && !key_valid &&
                        (tmr == TIMEOUT_CYCLES - 24'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (key_valid || !tmr_run || timeout_hit) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 24'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         digits_out  <= '0;
         count       <= '0;
         entry_valid <= 1'b0;
         entry_done  <= 1'b0;
         err         <= 1'b0;
      end else begin
         entry_done <= 1'b0;
         err        <= 1'b0;
         if (key_valid) begin
            unique case (1'b1)
               is_digit: begin
                  if (state == FULL) begin
                     err <= 1'b1;
                  end else if (state == DONE) begin
                     // A new code replaces the committed one
                     digits_out  <= {12'h000, key_code};
                     count       <= 3'd1;
                     entry_valid <= 1'b0;
                     state       <= ENTRY;
                  end else begin
                     digits_out <= {digits_out[11:0], key_code};
                     count      <= count + 3'd1;
                     state      <= (count == 3'd3) ? FULL : ENTRY;
                  end
               end
               is_clear: begin
                  digits_out  <= '0;
                  count       <= '0;
                  entry_valid <= 1'b0;
                  state       <= IDLE;
               end
               is_enter: begin
                  if (state == FULL) begin
                     state       <= DONE;
                     entry_valid <= 1'b1;
                     entry_done  <= 1'b1;
                  end else if (state != DONE) begin
                     err <= 1'b1;
                  end
               end
               is_rsvd: begin
               end
            endcase
         end else if (timeout_hit) begin
            digits_out  <= '0;
            count       <= '0;
            entry_valid <= 1'b0;
            state       <= IDLE;
            err         <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_digit_entry.sv
// Directed self-checking bench for digit_entry.
module tb_digit_entry;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] digits_out;
   logic [2:0]  count;
   logic        entry_valid;
   logic        entry_done;
   logic        err;

   int tests;
   int fails;

   digit_entry #(.TIMEOUT_CYCLES(24'd16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .digits_out (digits_out),
      .count      (count),
      .entry_valid(entry_valid),
      .entry_done (entry_done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      #12;
      tests++;
      if ({digits_out, count, entry_valid, entry_done, err} !== 22'd0) begin
         fails++;
         $display("FAIL reset: got %h/%0d/%b%b%b expected 0",
                  digits_out, count, entry_valid, entry_done, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_commit();
      press(4'h1);
      chk("commit_cnt1", {13'd0, count}, 16'd1);
      press(4'h2);
      press(4'h3);
      chk("commit_cnt3", {13'd0, count}, 16'd3);
      press(4'h4);
      chk("commit_dig", digits_out, 16'h1234);
      chk("commit_cnt4", {13'd0, count}, 16'd4);
      press(4'hB);
      chk("commit_done", {14'd0, entry_done, entry_valid}, 16'b11);
      chk("commit_err", {15'd0, err}, 16'd0);
      idle(1);
      chk("commit_hold", {14'd0, entry_done, entry_valid}, 16'b01);
      chk("commit_stable", digits_out, 16'h1234);
      press(4'hB);
      chk("enter_in_done", {13'd0, entry_done, entry_valid, err}, 16'b010);
   endtask

   task automatic test_early_enter();
      press(4'hA);
      press(4'h5);
      press(4'h6);
      press(4'hB);
      chk("early_err", {15'd0, err}, 16'd1);
      chk("early_cnt", {13'd0, count}, 16'd2);
      chk("early_dig", digits_out, 16'h0056);
      chk("early_valid", {15'd0, entry_valid}, 16'd0);
      idle(1);
      chk("early_err_pulse", {15'd0, err}, 16'd0);
   endtask

   task automatic test_full_reject();
      press(4'hA);
      press(4'h1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      press(4'h9);
      chk("full_err", {15'd0, err}, 16'd1);
      chk("full_dig", digits_out, 16'h1234);
      press(4'hA);
      chk("clear_dig", digits_out, 16'h0000);
      chk("clear_cnt_err", {12'd0, count, err}, 16'd0);
      press(4'hB);
      chk("clear_idle", {15'd0, err}, 16'd1);
   endtask

   task automatic test_restart();
      press(4'hA);
      press(4'h1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      press(4'hB);
      press(4'h7);
      chk("restart_valid", {15'd0, entry_valid}, 16'd0);
      chk("restart_dig", digits_out, 16'h0007);
      chk("restart_cnt", {13'd0, count}, 16'd1);
   endtask

   task automatic test_ignore();
      press(4'hA);
      press(4'h4);
      press(4'hC);
      press(4'hF);
      chk("rsvd_dig", digits_out, 16'h0004);
      chk("rsvd_cnt_err", {12'd0, count, err}, 16'b0010);
      @(negedge clk);
      key_code = 4'h5;
      idle(2);
      chk("novalid_dig", digits_out, 16'h0004);
   endtask

   task automatic test_back_to_back();
      press(4'hA);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'h1;
      @(negedge clk);
      key_code  = 4'h2;
      @(negedge clk);
      key_code  = 4'h3;
      @(negedge clk);
      key_code  = 4'h4;
      @(negedge clk);
      key_valid = 1'b0;
      chk("b2b_dig", digits_out, 16'h1234);
      chk("b2b_cnt", {13'd0, count}, 16'd4);
   endtask

   task automatic test_async_reset();
      press(4'hA);
      press(4'h8);
      press(4'h8);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({digits_out, count, entry_valid, entry_done, err} !== 22'd0) begin
         fails++;
         $display("FAIL async_reset: got %h/%0d expected 0/0",
                  digits_out, count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      press(4'h5);
      chk("post_reset_key", digits_out, 16'h0005);
      chk("post_reset_cnt", {13'd0, count}, 16'd1);
   endtask

`ifdef DIGIT_ENTRY_TIMEOUT_EN
   task automatic test_timeout();
      int errs;
      press(4'hA);
      press(4'h3);
      errs = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (err) errs++;
      end
      chk("to_early", errs[15:0], 16'd0);
      @(negedge clk);
      chk("to_err", {15'd0, err}, 16'd1);
      chk("to_cnt", {13'd0, count}, 16'd0);
      press(4'h3);
      idle(13);
      press(4'h4);
      errs = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (err) errs++;
      end
      chk("to_restart", errs[15:0], 16'd0);
      chk("to_restart_dig", digits_out, 16'h0034);
      @(negedge clk);
      chk("to_restart_err", {15'd0, err}, 16'd1);
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_commit();
      test_early_enter();
      test_full_reject();
      test_restart();
      test_ignore();
      test_back_to_back();
      test_async_reset();
`ifdef DIGIT_ENTRY_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
